qpsk_mod_tx: RTL and testbench

- QPSK transmit modulator for the RFNoC QPSK chain; the transmit-side counterpart of the Costas/bit-sync receiver.
- Takes packed 2-bit symbols from the axi_wrapper output stream (m_axis_data_*).
- Gray-maps each symbol to a constant-amplitude I/Q point and holds it for SPS samples (rectangular pulse).
- Emits 32-bit {I,Q} samples on the s_axis_data_* stream, preserving input packet boundaries.

---
 rtl/qpsk_mod_tx.sv | 118 +++++++++++
 tb/tb_qpsk_mod_tx.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_mod_tx.sv
// QPSK transmit modulator: Gray-maps packed 2-bit symbols to constant-amplitude
// I/Q points and holds each one for SPS samples, preserving packet boundaries.
module qpsk_mod_tx #(
  parameter int SPS          = 16,
  parameter int SYM_PER_WORD = 16
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        clear,
  input  logic [15:0] amp,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        busy
);

  localparam logic [7:0] LAST_SAMP = 8'(SPS - 1);
  localparam logic [3:0] LAST_SYM  = 4'(SYM_PER_WORD - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [15:0] amp_q, amp_d;
  logic        last_q, last_d;
  logic [3:0]  sym_q, sym_d;
  logic [7:0]  samp_q, samp_d;
  logic [31:0] data_q, data_d;
  logic        tlast_q, tlast_d;

  logic        finalSamp;
  logic        load;
  logic [4:0]  hiBit;
  logic [1:0]  symBits;
  logic [15:0] negAmp;

  assign finalSamp = (sym_q == LAST_SYM) && (samp_q == LAST_SAMP);
  assign i_tready  = (state_q == IDLE) || (finalSamp && o_tready);
  assign o_tvalid  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign o_tdata   = data_q;
  assign o_tlast   = tlast_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    amp_d   = amp_q;
    last_d  = last_q;
    sym_d   = sym_q;
    samp_d  = samp_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_tvalid) load = 1'b1;
      end
      RUN: begin
        if (o_tready) begin
          if (finalSamp) begin
            if (i_tvalid) load = 1'b1;
            else          state_d = IDLE;
          end else if (samp_q == LAST_SAMP) begin
            samp_d = 8'd0;
            sym_d  = sym_q + 4'd1;
          end else begin
            samp_d = samp_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A word load restarts the symbol walk and captures amplitude for the whole word
    if (load) begin
      state_d = RUN;
      word_d  = i_tdata;
      amp_d   = amp & 16'h7FFF;
      last_d  = i_tlast;
      sym_d   = 4'd0;
      samp_d  = 8'd0;
    end
    hiBit   = 5'd31 - {sym_d, 1'b0};
    symBits = {word_d[hiBit], word_d[hiBit - 5'd1]};
    negAmp  = ~amp_d + 16'd1;
    data_d  = '0;
    tlast_d = 1'b0;
    if (state_d == RUN) begin
      data_d  = {symBits[1] ? negAmp : amp_d, symBits[0] ? negAmp : amp_d};
      tlast_d = last_d && (sym_d == LAST_SYM) && (samp_d == LAST_SAMP);
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst || clear) begin
      state_q <= IDLE;
      word_q  <= '0;
      amp_q   <= '0;
      last_q  <= 1'b0;
      sym_q   <= '0;
      samp_q  <= '0;
      data_q  <= '0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      amp_q   <= amp_d;
      last_q  <= last_d;
      sym_q   <= sym_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      tlast_q <= tlast_d;
    end
  end

endmodule

// File: tb/tb_qpsk_mod_tx.sv
// Self-checking bench for qpsk_mod_tx: random words/amplitudes against a
// per-word symbol-expansion model, with optional random output backpressure.
module tb_qpsk_mod_tx;

   localparam int SPS        = 16;
   localparam int WORD_SAMPS = 16 * SPS;

   logic        ce_clk   = 1'b0;
   logic        ce_rst   = 1'b1;
   logic        clear    = 1'b0;
   logic [15:0] amp      = '0;
   logic [31:0] i_tdata  = '0;
   logic        i_tlast  = 1'b0;
   logic        i_tvalid = 1'b0;
   logic        i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready = 1'b1;
   logic        busy;

   typedef struct {
      logic [31:0] w;
      logic        last;
      logic [15:0] a;
   } item_t;

   item_t       inQ[$];
   logic [32:0] obsQ[$];
   logic [32:0] expQ[$];
   int          hsCyc[$];
   int          rdyIdx[$];
   int          cyc      = 0;
   int          stallBad = 0;
   bit          bpMode   = 1'b0;
   int          total    = 0;
   int          bad      = 0;

   qpsk_mod_tx #(.SPS(SPS), .SYM_PER_WORD(16)) dut (
      .ce_clk   (ce_clk),
      .ce_rst   (ce_rst),
      .clear    (clear),
      .amp      (amp),
      .i_tdata  (i_tdata),
      .i_tlast  (i_tlast),
      .i_tvalid (i_tvalid),
      .i_tready (i_tready),
      .o_tdata  (o_tdata),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .o_tready (o_tready),
      .busy     (busy)
   );

   always #5 ce_clk = ~ce_clk;

   // Bus driver and monitor: samples handshakes on the falling edge, then
   // presents the next queued word and a fresh o_tready just after the rising edge.
   initial begin : bfm
      logic        inHs;
      logic        outHs;
      logic        prevStall;
      logic [32:0] prevOut;
      prevStall = 1'b0;
      prevOut   = '0;
      forever begin
         @(negedge ce_clk);
         cyc++;
         inHs  = i_tvalid && i_tready && !ce_rst && !clear;
         outHs = o_tvalid && o_tready && !ce_rst && !clear;
         if (prevStall && ({o_tlast, o_tdata} !== prevOut)) stallBad++;
         prevStall = o_tvalid && !o_tready && !ce_rst && !clear;
         prevOut   = {o_tlast, o_tdata};
         if (outHs) begin
            obsQ.push_back({o_tlast, o_tdata});
            hsCyc.push_back(cyc);
            if (inHs) rdyIdx.push_back(obsQ.size());
         end
         @(posedge ce_clk);
         #1;
         if (inHs && inQ.size() > 0) inQ.delete(0);
         if (inQ.size() > 0) begin
            i_tvalid = 1'b1;
            i_tdata  = inQ[0].w;
            i_tlast  = inQ[0].last;
            amp      = inQ[0].a;
         end else begin
            i_tvalid = 1'b0;
            i_tdata  = $urandom;
            i_tlast  = 1'b0;
            amp      = 16'($urandom);
         end
         o_tready = bpMode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Reference: each word expands to 16 symbols, MSB pair first, each held SPS samples.
   function automatic void addExpected(item_t it);
      int         a;
      int         iv;
      int         qv;
      logic [1:0] s;
      logic [15:0] i16;
      logic [15:0] q16;
      a = int'(it.a) % 32768;
      for (int k = 0; k < 16; k++) begin
         s   = 2'((it.w >> (30 - 2 * k)) & 32'd3);
         iv  = s[1] ? -a : a;
         qv  = s[0] ? -a : a;
         i16 = iv[15:0];
         q16 = qv[15:0];
         for (int n = 0; n < SPS; n++)
            expQ.push_back({(it.last && k == 15 && n == SPS - 1), i16, q16});
      end
   endfunction

   task automatic queueItem(input logic [31:0] w, input logic last, input logic [15:0] a);
      item_t it;
      it.w    = w;
      it.last = last;
      it.a    = a;
      inQ.push_back(it);
      addExpected(it);
   endtask

   task automatic startTest();
      obsQ.delete();
      expQ.delete();
      hsCyc.delete();
      rdyIdx.delete();
   endtask

   task automatic waitDrain(output bit timedOut);
      int budget;
      budget   = expQ.size() * 4 + 200;
      timedOut = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(negedge ce_clk);
         #1;
         if (obsQ.size() >= expQ.size()) begin
            timedOut = 1'b0;
            break;
         end
      end
      @(negedge ce_clk);
      #1;
   endtask

   function automatic int firstDiff();
      for (int k = 0; k < expQ.size(); k++)
         if (k >= obsQ.size() || obsQ[k] !== expQ[k]) return k;
      return -1;
   endfunction

   function automatic logic [32:0] obsAt(int k);
      if (k >= 0 && k < obsQ.size()) return obsQ[k];
      return 'x;
   endfunction

   function automatic int countLast();
      int n;
      n = 0;
      foreach (obsQ[k]) if (obsQ[k][32]) n++;
      return n;
   endfunction

   task automatic test_reset();
      ce_rst = 1'b1;
      repeat (3) @(posedge ce_clk);
      #2;
      ce_rst = 1'b0;
      @(negedge ce_clk);
      #1;
      total++;
      if ({o_tvalid, o_tlast, busy, i_tready} !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0001", {o_tvalid, o_tlast, busy, i_tready});
      end
      total++;
      if (o_tdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_data: got %h expected 00000000", o_tdata);
      end
   endtask

   task automatic test_basic_mapping();
      bit to;
      int d;
      startTest();
      queueItem(32'h0000_0000, 1'b1, 16'h2000);
      waitDrain(to);
      total++;
      if (to !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_timeout: got %0d samples expected %0d", obsQ.size(), expQ.size());
      end
      total++;
      if (obsQ.size() !== WORD_SAMPS) begin
         bad++;
         $display("[TB] FAIL basic_count: got %0d expected %0d", obsQ.size(), WORD_SAMPS);
      end
      d = firstDiff();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL basic_seq at %0d: got %h expected %h", d, obsAt(d), expQ[d]);
      end
      total++;
      if (obsAt(WORD_SAMPS - 1) !== 33'h1_2000_2000 || countLast() != 1) begin
         bad++;
         $display("[TB] FAIL basic_tlast: got last=%h count=%0d expected 120002000 count=1", obsAt(WORD_SAMPS - 1), countLast());
      end
      total++;
      if ({busy, o_tvalid, i_tready} !== 3'b001) begin
         bad++;
         $display("[TB] FAIL basic_idle_after: got %b expected 001", {busy, o_tvalid, i_tready});
      end
   endtask

   task automatic test_gray_map();
      bit          to;
      int          d;
      logic [32:0] pts[5];
      pts[0] = 33'h0_2000_2000;
      pts[1] = 33'h0_2000_E000;
      pts[2] = 33'h0_E000_2000;
      pts[3] = 33'h0_E000_E000;
      pts[4] = 33'h0_2000_2000;
      startTest();
      queueItem(32'h1B00_0000, 1'b1, 16'h2000);
      waitDrain(to);
      for (int p = 0; p < 5; p++) begin
         total++;
         if (obsAt(p * SPS + SPS - 1) !== pts[p]) begin
            bad++;
            $display("[TB] FAIL gray_point%0d: got %h expected %h", p, obsAt(p * SPS + SPS - 1), pts[p]);
         end
      end
      d = firstDiff();
      total++;
      if (d != -1 || to) begin
         bad++;
         $display("[TB] FAIL gray_seq at %0d: got %h expected %h", d, obsAt(d), (d >= 0) ? expQ[d] : 33'h0);
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      int d;
      startTest();
      for (int k = 0; k < 3; k++) queueItem($urandom, k == 2, 16'($urandom));
      waitDrain(to);
      d = firstDiff();
      total++;
      if (d != -1 || obsQ.size() !== 3 * WORD_SAMPS || to) begin
         bad++;
         $display("[TB] FAIL b2b_seq at %0d: got %h (n=%0d) expected %h (n=%0d)", d, obsAt(d), obsQ.size(), (d >= 0) ? expQ[d] : 33'h0, 3 * WORD_SAMPS);
      end
      total++;
      if (hsCyc.size() != 3 * WORD_SAMPS || hsCyc[hsCyc.size() - 1] - hsCyc[0] != 3 * WORD_SAMPS - 1) begin
         bad++;
         $display("[TB] FAIL b2b_gapless: got span %0d expected %0d", (hsCyc.size() > 0) ? hsCyc[hsCyc.size() - 1] - hsCyc[0] : -1, 3 * WORD_SAMPS - 1);
      end
      total++;
      if (rdyIdx.size() != 2 || rdyIdx[0] != WORD_SAMPS || rdyIdx[1] != 2 * WORD_SAMPS) begin
         bad++;
         $display("[TB] FAIL b2b_ready_pulses: got n=%0d first=%0d expected 2 at %0d,%0d", rdyIdx.size(), (rdyIdx.size() > 0) ? rdyIdx[0] : -1, WORD_SAMPS, 2 * WORD_SAMPS);
      end
      total++;
      if (countLast() != 1) begin
         bad++;
         $display("[TB] FAIL b2b_tlast_count: got %0d expected 1", countLast());
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int d;
      int stallBase;
      startTest();
      stallBase = stallBad;
      bpMode    = 1'b1;
      queueItem($urandom, 1'b0, 16'($urandom));
      queueItem($urandom, 1'b1, 16'($urandom));
      waitDrain(to);
      bpMode = 1'b0;
      d = firstDiff();
      total++;
      if (d != -1 || obsQ.size() !== 2 * WORD_SAMPS || to) begin
         bad++;
         $display("[TB] FAIL bp_seq at %0d: got %h (n=%0d) expected %h (n=%0d)", d, obsAt(d), obsQ.size(), (d >= 0) ? expQ[d] : 33'h0, 2 * WORD_SAMPS);
      end
      total++;
      if (stallBad != stallBase) begin
         bad++;
         $display("[TB] FAIL bp_stable: got %0d unstable stalls expected 0", stallBad - stallBase);
      end
   endtask

   task automatic test_amp_edges();
      bit to;
      int d;
      int nz;
      startTest();
      queueItem(32'hFFFF_FFFF, 1'b1, 16'hFFFF);
      waitDrain(to);
      total++;
      if (obsAt(7) !== 33'h0_8001_8001 || firstDiff() != -1) begin
         bad++;
         $display("[TB] FAIL amp_max: got %h expected 080018001", obsAt(7));
      end
      startTest();
      queueItem($urandom, 1'b1, 16'h8000);
      waitDrain(to);
      nz = 0;
      foreach (obsQ[k]) if (obsQ[k][31:0] !== 32'h0) nz++;
      total++;
      if (nz != 0 || obsQ.size() != WORD_SAMPS) begin
         bad++;
         $display("[TB] FAIL amp_zero: got %0d nonzero of %0d expected 0 of %0d", nz, obsQ.size(), WORD_SAMPS);
      end
      startTest();
      queueItem(32'h0000_0000, 1'b0, 16'h1234);
      queueItem(32'h0000_0000, 1'b1, 16'h0567);
      waitDrain(to);
      total++;
      if (obsAt(WORD_SAMPS - 1) !== 33'h0_1234_1234 || obsAt(WORD_SAMPS) !== 33'h0_0567_0567) begin
         bad++;
         $display("[TB] FAIL amp_midword: got %h,%h expected 012341234,005670567", obsAt(WORD_SAMPS - 1), obsAt(WORD_SAMPS));
      end
      d = firstDiff();
      total++;
      if (d != -1 || to) begin
         bad++;
         $display("[TB] FAIL amp_midword_seq at %0d: got %h expected %h", d, obsAt(d), (d >= 0) ? expQ[d] : 33'h0);
      end
   endtask

   task automatic test_clear_midpacket(input bit useRst);
      bit to;
      int d;
      startTest();
      queueItem($urandom, 1'b0, 16'($urandom));
      queueItem($urandom, 1'b1, 16'($urandom));
      to = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge ce_clk);
         #1;
         if (obsQ.size() >= WORD_SAMPS + 100) begin
            to = 1'b0;
            break;
         end
      end
      total++;
      if (to) begin
         bad++;
         $display("[TB] FAIL flush%0d_reach: got %0d samples expected %0d", useRst, obsQ.size(), WORD_SAMPS + 100);
      end
      @(posedge ce_clk);
      #2;
      inQ.delete();
      if (useRst) ce_rst = 1'b1;
      else        clear  = 1'b1;
      @(posedge ce_clk);
      #2;
      ce_rst = 1'b0;
      clear  = 1'b0;
      @(negedge ce_clk);
      #1;
      total++;
      if ({o_tvalid, o_tlast, busy, i_tready} !== 4'b0001 || o_tdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL flush%0d_state: got %b data %h expected 0001 data 00000000", useRst, {o_tvalid, o_tlast, busy, i_tready}, o_tdata);
      end
      total++;
      if (countLast() != 0) begin
         bad++;
         $display("[TB] FAIL flush%0d_no_tlast: got %0d expected 0", useRst, countLast());
      end
      startTest();
      queueItem($urandom, 1'b1, 16'($urandom));
      waitDrain(to);
      d = firstDiff();
      total++;
      if (d != -1 || obsQ.size() != WORD_SAMPS || to) begin
         bad++;
         $display("[TB] FAIL flush%0d_fresh at %0d: got %h (n=%0d) expected %h (n=%0d)", useRst, d, obsAt(d), obsQ.size(), (d >= 0) ? expQ[d] : 33'h0, WORD_SAMPS);
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_basic_mapping();
      test_gray_map();
      test_back_to_back();
      test_backpressure();
      test_amp_edges();
      test_clear_midpacket(1'b0);
      test_clear_midpacket(1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
